// File: rtl/run_checker_if.sv
// Sample stream and violation outputs of the colour-run checker.
// The bench drives through master and the checker sits on slave.
interface run_checker_if #(
  parameter int COLOR_W = 2,
  parameter int CNT_W   = 8,
  parameter int RUN_W   = 2
);
  logic               in_valid;
  logic [COLOR_W-1:0] color;
  logic               sticky;
  logic               clr;
  logic               check;
  logic               err_run;
  logic               err_pair;
  logic [CNT_W-1:0]   err_cnt;
  logic [RUN_W-1:0]   run_len;

  modport master (
    output in_valid, color, sticky, clr,
    input  check, err_run, err_pair,
    input  err_cnt, run_len
  );

  modport slave (
    input  in_valid, color, sticky, clr,
    output check, err_run, err_pair,
    output err_cnt, run_len
  );
endinterface

// File: rtl/run_checker.sv
// Colour-stream checker: flags over-long runs and forbidden
// colour transitions, with sticky/pulse check and a violation count.
module run_checker #(
  parameter int COLOR_W = 2,
  parameter logic [COLOR_W-1:0] IDLE_CODE = {COLOR_W{1'b1}},
  parameter int MAX_RUN = 2,
  parameter logic [2**(2*COLOR_W)-1:0] FORBID = 16'h0012,
  parameter int CNT_W = 8,
  parameter int RUN_W = $clog2(MAX_RUN+1)
) (
  input logic          clk,
  input logic          rst_n,
  run_checker_if.slave io
);

  // run_q == 0 encodes EMPTY; in HOLD the count is always >= 1
  logic [COLOR_W-1:0] prev_q, prev_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic               check_q, check_d;
  logic               erun_q, erun_d;
  logic               epair_q, epair_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic v_run;
  logic v_pair;
  logic viol;
  logic same;

  assign same = (io.color == prev_q);
  assign viol = v_run | v_pair;

  always_comb begin
    prev_d = prev_q;
    run_d  = run_q;
    v_run  = 1'b0;
    v_pair = 1'b0;
    if (io.in_valid) begin
      if (io.color == IDLE_CODE) begin
        run_d = '0;
      end else if (run_q == '0) begin
        prev_d = io.color;
        run_d  = RUN_W'(1);
      end else if (FORBID[{prev_q, io.color}]) begin
        v_pair = 1'b1;
      end else if (same && run_q == RUN_W'(MAX_RUN)) begin
        v_run = 1'b1;
      end else if (same) begin
        run_d = run_q + RUN_W'(1);
      end else begin
        prev_d = io.color;
        run_d  = RUN_W'(1);
      end
    end
  end

  always_comb begin
    check_d = check_q;
    erun_d  = erun_q;
    epair_d = epair_q;
    cnt_d   = cnt_q;
    if (io.in_valid) begin
      check_d = viol | (io.sticky & check_q);
      erun_d  = v_run;
      epair_d = v_pair;
      if (viol && cnt_q != {CNT_W{1'b1}})
        cnt_d = cnt_q + CNT_W'(1);
    end
    // clear wins over a violation on the same edge
    if (io.clr) begin
      check_d = 1'b0;
      erun_d  = 1'b0;
      epair_d = 1'b0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= '0;
      run_q   <= '0;
      check_q <= 1'b0;
      erun_q  <= 1'b0;
      epair_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      prev_q  <= prev_d;
      run_q   <= run_d;
      check_q <= check_d;
      erun_q  <= erun_d;
      epair_q <= epair_d;
      cnt_q   <= cnt_d;
    end
  end

  assign io.check    = check_q;
  assign io.err_run  = erun_q;
  assign io.err_pair = epair_q;
  assign io.err_cnt  = cnt_q;
  assign io.run_len  = run_q;

endmodule

// File: tb/tb_run_checker.sv
// Directed bench for run_checker: default instance plus a
// narrow-counter instance to exercise saturation.
module tb_run_checker;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  run_checker_if #(.COLOR_W(2), .CNT_W(8), .RUN_W(2)) ia ();
  run_checker_if #(.COLOR_W(2), .CNT_W(2), .RUN_W(2)) ib ();

  run_checker u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (ia)
  );

  run_checker #(.CNT_W(2)) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step_a(input logic v, input logic [1:0] c,
                        input logic s, input logic cl);
    ia.in_valid = v;
    ia.color    = c;
    ia.sticky   = s;
    ia.clr      = cl;
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input logic v, input logic [1:0] c);
    ib.in_valid = v;
    ib.color    = c;
    ib.sticky   = 1'b0;
    ib.clr      = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic ck,
                       input logic er, input logic ep,
                       input int cnt, input int rl);
    chk({tag, ".check"},    32'(ia.check),    32'(ck));
    chk({tag, ".err_run"},  32'(ia.err_run),  32'(er));
    chk({tag, ".err_pair"}, 32'(ia.err_pair), 32'(ep));
    chk({tag, ".err_cnt"},  32'(ia.err_cnt),  32'(cnt));
    chk({tag, ".run_len"},  32'(ia.run_len),  32'(rl));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    ia.in_valid = 1'b0; ia.color = 2'd0;
    ia.sticky = 1'b0;   ia.clr = 1'b0;
    ib.in_valid = 1'b0; ib.color = 2'd0;
    ib.sticky = 1'b0;   ib.clr = 1'b0;
    #3;
    chk_a("reset", 0, 0, 0, 0, 0);
    chk("reset.b_cnt", 32'(ib.err_cnt), 32'd0);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // run of 2s with MAX_RUN=2
    step_a(1, 2'd2, 0, 0); chk_a("run1", 0, 0, 0, 0, 1);
    step_a(1, 2'd2, 0, 0); chk_a("run2", 0, 0, 0, 0, 2);
    step_a(1, 2'd2, 0, 0); chk_a("run3", 1, 1, 0, 1, 2);
    step_a(1, 2'd2, 0, 0); chk_a("run4", 1, 1, 0, 2, 2);
    step_a(1, 2'd3, 0, 0); chk_a("idle1", 0, 0, 0, 2, 0);

    // forbidden 0->1, rejected sample keeps history
    step_a(1, 2'd0, 0, 0); chk_a("pair0", 0, 0, 0, 2, 1);
    step_a(1, 2'd1, 0, 0); chk_a("pair1", 1, 0, 1, 3, 1);
    step_a(1, 2'd0, 0, 0); chk_a("pair2", 0, 0, 0, 3, 2);
    step_a(1, 2'd3, 0, 0); chk_a("idle2", 0, 0, 0, 3, 0);

    // idle in between clears history
    step_a(1, 2'd0, 0, 0); chk_a("seq0", 0, 0, 0, 3, 1);
    step_a(1, 2'd3, 0, 0); chk_a("seq3", 0, 0, 0, 3, 0);
    step_a(1, 2'd1, 0, 0); chk_a("seq1", 0, 0, 0, 3, 1);
    step_a(0, 2'd0, 0, 0); chk_a("novalid", 0, 0, 0, 3, 1);
    step_a(1, 2'd3, 0, 0); chk_a("idle3", 0, 0, 0, 3, 0);

    // sticky mode then clear
    step_a(1, 2'd0, 1, 0); chk_a("stk0", 0, 0, 0, 3, 1);
    step_a(1, 2'd1, 1, 0); chk_a("stk1", 1, 0, 1, 4, 1);
    step_a(1, 2'd2, 1, 0); chk_a("stk2", 1, 0, 0, 4, 1);
    step_a(1, 2'd2, 1, 0); chk_a("stk3", 1, 0, 0, 4, 2);
    step_a(0, 2'd1, 1, 0); chk_a("stkhold", 1, 0, 0, 4, 2);
    step_a(1, 2'd2, 1, 1); chk_a("clr", 0, 0, 0, 0, 2);
    step_a(1, 2'd2, 0, 0); chk_a("postclr", 1, 1, 0, 1, 2);
    step_a(0, 2'd0, 0, 1); chk_a("clrnv", 0, 0, 0, 0, 2);
    step_a(1, 2'd3, 0, 0); chk_a("idle4", 0, 0, 0, 0, 0);
    ia.in_valid = 1'b0;

    // narrow counter saturation on the second instance
    step_b(1, 2'd1);
    step_b(1, 2'd1);
    chk("sat.run", 32'(ib.run_len), 32'd2);
    step_b(1, 2'd1); chk("sat.c1", 32'(ib.err_cnt), 32'd1);
    step_b(1, 2'd1); chk("sat.c2", 32'(ib.err_cnt), 32'd2);
    step_b(1, 2'd1); chk("sat.c3", 32'(ib.err_cnt), 32'd3);
    step_b(1, 2'd1); chk("sat.c4", 32'(ib.err_cnt), 32'd3);
    step_b(1, 2'd1); chk("sat.c5", 32'(ib.err_cnt), 32'd3);
    step_b(0, 2'd2); step_b(0, 2'd0);
    chk("sat.nv_cnt",   32'(ib.err_cnt), 32'd3);
    chk("sat.nv_check", 32'(ib.check),   32'd1);
    chk("sat.nv_run",   32'(ib.run_len), 32'd2);
    ib.in_valid = 1'b0;

    // async reset between edges
    step_a(1, 2'd1, 0, 0);
    step_a(1, 2'd1, 0, 0); chk_a("prerst", 0, 0, 0, 0, 2);
    step_a(1, 2'd1, 0, 0); chk_a("prerst2", 1, 1, 0, 1, 2);
    ia.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_a("asyncrst", 0, 0, 0, 0, 0);
    chk("asyncrst.b", 32'(ib.err_cnt), 32'd0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step_a(1, 2'd1, 0, 0); chk_a("rel1", 0, 0, 0, 0, 1);
    step_a(1, 2'd1, 0, 0); chk_a("rel2", 0, 0, 0, 0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
